// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two writeback queues (integer, FPU)
// merged round-robin onto one register-file write port.
module regfile_write_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_valid,
    output logic        int_ready,
    input  logic [5:0]  int_reg,
    input  logic [31:0] int_data,
    input  logic        fp_valid,
    output logic        fp_ready,
    input  logic [5:0]  fp_reg,
    input  logic        fp_float,
    input  logic [31:0] fp_data,
    output logic [5:0]  rf_writeReg,
    output logic [31:0] rf_writeData,
    output logic        rf_regWrite,
    output logic        rf_float,
    input  logic [5:0]  chk_reg,
    input  logic        chk_float,
    output logic        chk_hit,
    output logic        err_badreg,
    output logic        idle
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(QDEPTH);

    logic [5:0]    iq_reg  [QDEPTH];
    logic [31:0]   iq_data [QDEPTH];
    logic [AW-1:0] iq_wr;
    logic [AW-1:0] iq_rd;
    logic [AW:0]   iq_cnt;
    logic [AW:0]   iq_cnt_nxt;

    logic [5:0]    fq_reg   [QDEPTH];
    logic [31:0]   fq_data  [QDEPTH];
    logic          fq_float [QDEPTH];
    logic [AW-1:0] fq_wr;
    logic [AW-1:0] fq_rd;
    logic [AW:0]   fq_cnt;
    logic [AW:0]   fq_cnt_nxt;

    logic int_hs;
    logic fp_hs;
    logic int_push;
    logic fp_push;
    logic iq_ne;
    logic fq_ne;
    logic grant_int;
    logic grant_fp;
    logic last_fp;

    // True when slot idx lies inside the occupied window of a queue.
    function automatic logic in_win(
        input logic [AW-1:0] idx,
        input logic [AW-1:0] rd,
        input logic [AW:0]   cnt
    );
        logic [AW-1:0] off;
        off = idx - rd;
        return {1'b0, off} < cnt;
    endfunction

    assign int_hs = int_valid && int_ready;
    assign fp_hs  = fp_valid && fp_ready;

    // Out-of-range and integer x0 requests are consumed but never queued.
    assign int_push = int_hs && !int_reg[5] && (int_reg != 6'd0);
    assign fp_push  = fp_hs && !fp_reg[5] && (fp_float || (fp_reg != 6'd0));

    assign iq_ne = (iq_cnt != '0);
    assign fq_ne = (fq_cnt != '0);

    assign grant_int = iq_ne && (!fq_ne || last_fp);
    assign grant_fp  = fq_ne && !grant_int;

    assign idle = !iq_ne && !fq_ne && !rf_regWrite;

    // Next occupancy of both queues from push/pop of this cycle.
    always_comb begin
        iq_cnt_nxt = iq_cnt;
        fq_cnt_nxt = fq_cnt;
        if (int_push && !grant_int) iq_cnt_nxt = iq_cnt + (AW + 1)'(1);
        if (!int_push && grant_int) iq_cnt_nxt = iq_cnt - (AW + 1)'(1);
        if (fp_push && !grant_fp)   fq_cnt_nxt = fq_cnt + (AW + 1)'(1);
        if (!fp_push && grant_fp)   fq_cnt_nxt = fq_cnt - (AW + 1)'(1);
    end

    // Queue storage; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (int_push) begin
            iq_reg[iq_wr]  <= int_reg;
            iq_data[iq_wr] <= int_data;
        end
        if (fp_push) begin
            fq_reg[fq_wr]   <= fp_reg;
            fq_data[fq_wr]  <= fp_data;
            fq_float[fq_wr] <= fp_float;
        end
    end

    // Integer queue pointers, count and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iq_wr     <= '0;
            iq_rd     <= '0;
            iq_cnt    <= '0;
            int_ready <= 1'b0;
        end else begin
            if (int_push)  iq_wr <= iq_wr + AW'(1);
            if (grant_int) iq_rd <= iq_rd + AW'(1);
            iq_cnt    <= iq_cnt_nxt;
            int_ready <= (iq_cnt_nxt != FULL);
        end
    end

    // FPU queue pointers, count and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fq_wr    <= '0;
            fq_rd    <= '0;
            fq_cnt   <= '0;
            fp_ready <= 1'b0;
        end else begin
            if (fp_push)  fq_wr <= fq_wr + AW'(1);
            if (grant_fp) fq_rd <= fq_rd + AW'(1);
            fq_cnt   <= fq_cnt_nxt;
            fp_ready <= (fq_cnt_nxt != FULL);
        end
    end

    // Write port, round-robin state and bad-index pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_regWrite  <= 1'b0;
            rf_writeReg  <= '0;
            rf_writeData <= '0;
            rf_float     <= 1'b0;
            last_fp      <= 1'b1;
            err_badreg   <= 1'b0;
        end else begin
            rf_regWrite <= grant_int || grant_fp;
            if (grant_int) begin
                rf_writeReg  <= iq_reg[iq_rd];
                rf_writeData <= iq_data[iq_rd];
                rf_float     <= 1'b0;
                last_fp      <= 1'b0;
            end else if (grant_fp) begin
                rf_writeReg  <= fq_reg[fq_rd];
                rf_writeData <= fq_data[fq_rd];
                rf_float     <= fq_float[fq_rd];
                last_fp      <= 1'b1;
            end
            err_badreg <= (int_hs && int_reg[5]) || (fp_hs && fp_reg[5]);
        end
    end

    // Hazard query against queued entries and the write on the port.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (in_win(AW'(i), iq_rd, iq_cnt) && !chk_float &&
                (iq_reg[i] == chk_reg))
                chk_hit = 1'b1;
            if (in_win(AW'(i), fq_rd, fq_cnt) &&
                (fq_float[i] == chk_float) && (fq_reg[i] == chk_reg))
                chk_hit = 1'b1;
        end
        if (rf_regWrite && (rf_float == chk_float) &&
            (rf_writeReg == chk_reg))
            chk_hit = 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: the driver pushes expected
// writes, a negedge monitor pops and compares every rf write.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_valid;
    logic        int_ready;
    logic [5:0]  int_reg;
    logic [31:0] int_data;
    logic        fp_valid;
    logic        fp_ready;
    logic [5:0]  fp_reg;
    logic        fp_float;
    logic [31:0] fp_data;
    logic [5:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic        rf_regWrite;
    logic        rf_float;
    logic [5:0]  chk_reg;
    logic        chk_float;
    logic        chk_hit;
    logic        err_badreg;
    logic        idle;

    typedef struct {
        logic        fl;
        logic [5:0]  r;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t iq[$];
    exp_t fq[$];
    int   glog[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ni = 0;
    int   nf = 0;

    regfile_write_arbiter #(.QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .int_valid(int_valid), .int_ready(int_ready),
        .int_reg(int_reg), .int_data(int_data),
        .fp_valid(fp_valid), .fp_ready(fp_ready),
        .fp_reg(fp_reg), .fp_float(fp_float), .fp_data(fp_data),
        .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
        .rf_regWrite(rf_regWrite), .rf_float(rf_float),
        .chk_reg(chk_reg), .chk_float(chk_float), .chk_hit(chk_hit),
        .err_badreg(err_badreg), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic bit hit_exp(input exp_t e);
        return (e.fl == rf_float) && (e.r == rf_writeReg) &&
               (e.d == rf_writeData);
    endfunction

    // Monitor: every write on the port must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   src;
        if (rf_regWrite === 1'b1) begin
            total++;
            src = -1;
            if (iq.size() > 0 && hit_exp(iq[0])) begin
                e = iq.pop_front();
                src = 0;
            end else if (fq.size() > 0 && hit_exp(fq[0])) begin
                e = fq.pop_front();
                src = 1;
            end
            if (src < 0) begin
                bad++;
                $display("FAIL write: got f=%0d r=%0d d=%08h, no match (iq=%0d fq=%0d)",
                         rf_float, rf_writeReg, rf_writeData, iq.size(), fq.size());
            end else begin
                glog.push_back(src);
                if (e.cyc >= 0) begin
                    total++;
                    if (cyc != e.cyc) begin
                        bad++;
                        $display("FAIL latency r=%0d: got edge %0d expected %0d",
                                 e.r, cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit writable(input logic [5:0] r, input logic fl);
        return !r[5] && (fl || r != 6'd0);
    endfunction

    // Issue one cycle of requests; caller is at a negedge.
    task automatic send2(input bit di, input logic [5:0] ir,
                         input logic [31:0] id, input bit df,
                         input logic [5:0] fr, input logic ff,
                         input logic [31:0] fd, input bit lat);
        bit   hi;
        bit   hf;
        exp_t e;
        int_valid = di; int_reg = ir; int_data = id;
        fp_valid = df; fp_reg = fr; fp_float = ff; fp_data = fd;
        hi = di && int_ready;
        hf = df && fp_ready;
        @(posedge clk);
        #1;
        int_valid = 1'b0;
        fp_valid = 1'b0;
        if (di) check("int accept", 32'(hi), 32'd1);
        if (df) check("fp accept", 32'(hf), 32'd1);
        if (hi && writable(ir, 1'b0)) begin
            e = '{1'b0, ir, id, lat ? cyc + 1 : -1};
            iq.push_back(e);
        end
        if (hf && writable(fr, ff)) begin
            e = '{ff, fr, fd, lat ? cyc + 1 : -1};
            fq.push_back(e);
        end
    endtask

    // Both requesters valid every cycle; accept whatever ready allows.
    task automatic contest(input int n, input bit chk_rdy);
        bit   hi;
        bit   hf;
        exp_t e;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            int_valid = 1'b1;
            int_reg = 6'(1 + (ni % 30));
            int_data = 32'h1000_0000 + 32'(ni);
            fp_valid = 1'b1;
            fp_reg = 6'(10 + (nf % 20));
            fp_float = nf[0];
            fp_data = 32'h2000_0000 + 32'(nf);
            if (chk_rdy && t >= 2) begin
                check($sformatf("int_ready t=%0d", t), 32'(int_ready),
                      32'(t % 2 == 0));
                check($sformatf("fp_ready t=%0d", t), 32'(fp_ready),
                      32'(t % 2 == 1));
            end
            hi = int_ready;
            hf = fp_ready;
            @(posedge clk);
            #1;
            int_valid = 1'b0;
            fp_valid = 1'b0;
            if (hi) begin
                e = '{1'b0, int_reg, int_data, -1};
                iq.push_back(e);
                ni++;
            end
            if (hf) begin
                e = '{fp_float, fp_reg, fp_data, -1};
                fq.push_back(e);
                nf++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((iq.size() > 0 || fq.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (iq.size() > 0 || fq.size() > 0) begin
            bad++;
            $display("FAIL drain: got iq=%0d fq=%0d expected 0 0",
                     iq.size(), fq.size());
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " rf_regWrite"}, 32'(rf_regWrite), 32'd0);
        check({tag, " rf_writeReg"}, 32'(rf_writeReg), 32'd0);
        check({tag, " rf_writeData"}, rf_writeData, 32'd0);
        check({tag, " rf_float"}, 32'(rf_float), 32'd0);
        check({tag, " err_badreg"}, 32'(err_badreg), 32'd0);
        check({tag, " idle"}, 32'(idle), 32'd1);
        check({tag, " int_ready"}, 32'(int_ready), 32'd0);
        check({tag, " fp_ready"}, 32'(fp_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        int_valid = 1'b0; int_reg = '0; int_data = '0;
        fp_valid = 1'b0; fp_reg = '0; fp_float = 1'b0; fp_data = '0;
        chk_reg = '0; chk_float = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready int after reset", 32'(int_ready), 32'd1);
        check("ready fp after reset", 32'(fp_ready), 32'd1);

        // single int write, latency and idle
        send2(1, 6'd5, 32'hDEAD_BEEF, 0, 6'd0, 1'b0, 32'd0, 1);
        @(negedge clk);
        check("idle while queued", 32'(idle), 32'd0);
        @(negedge clk);
        check("write r5 visible", 32'(rf_regWrite), 32'd1);
        @(negedge clk);
        check("idle after write", 32'(idle), 32'd1);

        // int x0 dropped, float f0 written, out-of-range errors
        send2(1, 6'd0, 32'h1111_0000, 0, 6'd0, 1'b0, 32'd0, 0);
        @(negedge clk);
        check("err int x0", 32'(err_badreg), 32'd0);
        check("idle int x0", 32'(idle), 32'd1);
        send2(0, 6'd0, 32'd0, 1, 6'd0, 1'b1, 32'h2222_0000, 1);
        @(negedge clk);
        check("err fp f0", 32'(err_badreg), 32'd0);
        send2(0, 6'd0, 32'd0, 1, 6'd40, 1'b1, 32'h3333_0000, 0);
        @(negedge clk);
        check("err fp 40", 32'(err_badreg), 32'd1);
        @(negedge clk);
        check("err fp 40 clear", 32'(err_badreg), 32'd0);
        send2(1, 6'd33, 32'h3333_0001, 1, 6'd40, 1'b0, 32'h3333_0002, 0);
        @(negedge clk);
        check("err both bad", 32'(err_badreg), 32'd1);
        @(negedge clk);
        check("err both bad clear", 32'(err_badreg), 32'd0);
        drain();

        // hazard query on a queued float entry
        send2(0, 6'd0, 32'd0, 1, 6'd3, 1'b1, 32'h4444_0000, 1);
        chk_reg = 6'd3;
        chk_float = 1'b1;
        @(negedge clk);
        check("chk_hit f3 queued", 32'(chk_hit), 32'd1);
        chk_float = 1'b0;
        #1;
        check("chk_hit x3 queued", 32'(chk_hit), 32'd0);
        chk_float = 1'b1;
        @(negedge clk);
        check("chk_hit f3 on port", 32'(chk_hit), 32'd1);
        @(negedge clk);
        check("chk_hit f3 retired", 32'(chk_hit), 32'd0);
        check("hold rf_writeReg", 32'(rf_writeReg), 32'd3);
        check("hold rf_float", 32'(rf_float), 32'd1);
        drain();

        // round-robin under full contention, fresh last-grant
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        glog.delete();
        ni = 0;
        nf = 0;
        contest(10, 1);
        drain();
        check("no loss", 32'(glog.size()), 32'(ni + nf));
        foreach (glog[i])
            check($sformatf("grant %0d", i), 32'(glog[i]), 32'(i % 2));

        // reset with both queues loaded
        contest(4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        iq.delete();
        fq.delete();
        @(negedge clk);
        reset_checks("midreset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready int after midreset", 32'(int_ready), 32'd1);
        check("ready fp after midreset", 32'(fp_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("no write after reset", 32'(rf_regWrite), 32'd0);
            check("idle after reset", 32'(idle), 32'd1);
            @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter QDEPTH, default 2, meaning entries per requester queue (power of two, >=2).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 int_valid  input  1  integer-pipeline writeback request valid.
REQ-005 int_ready  output  1  integer queue can accept; registered, independent of int_valid.
REQ-006 int_reg  input  6  integer-bank destination index.
REQ-007 int_data  input  32  integer writeback data.
REQ-008 fp_valid  input  1  FPU writeback request valid.
REQ-009 fp_ready  output  1  FPU queue can accept; registered, independent of fp_valid.
REQ-010 fp_reg  input  6  destination index.
REQ-011 fp_float  input  1  1 = float bank, 0 = integer bank (FPU compare/move results).
REQ-012 fp_data  input  32  FPU writeback data.
REQ-013 rf_writeReg  output  6  register-file write index, registered.
REQ-014 rf_writeData  output  32  register-file write data, registered.
REQ-015 rf_regWrite  output  1  register-file write enable, registered, one cycle per write.
REQ-016 rf_float  output  1  register-file bank select for the write, registered.
REQ-017 chk_reg  input  6  hazard-query index from decode.
REQ-018 chk_float  input  1  hazard-query bank.
REQ-019 chk_hit  output  1  combinational: 1 if any queued valid entry, or the write currently on rf_*, matches {chk_float, chk_reg}.
REQ-020 err_badreg  output  1  registered one-cycle pulse on a discarded out-of-range request.
REQ-021 idle  output  1  1 when both queues are empty and rf_regWrite is 0.

Function
REQ-022 Accept on the rising edge where valid && ready; int requests carry float=0.
- Ready = queue not full at start of cycle.
- No ready-on-pop: a full queue does not accept in the same cycle it is popped.
REQ-023 Index with bit 5 set: request consumed (handshake completes), not enqueued, no write, err_badreg = 1 for the following cycle.
- Both requesters bad in same cycle: a single pulse.
REQ-024 Integer-bank index 0: request consumed, not enqueued, no write, no error; float-bank index 0 is a normal write.
REQ-025 Each queue is strict FIFO; push and pop in the same cycle on a non-full, non-empty queue keep occupancy unchanged.
REQ-026 Arbitration each cycle over queue heads:
- One queue non-empty: grant it.
- Both non-empty: grant the queue not granted last (round-robin); a single-candidate grant also updates last-grant.
REQ-027 A granted head is popped on the edge; on the same edge rf_* load that entry and rf_regWrite = 1 for exactly that cycle.
- No grant: rf_regWrite = 0; rf_writeReg, rf_writeData and rf_float hold their previous values.
REQ-028 Latency: request accepted at edge k with its queue otherwise empty and uncontested drives rf_regWrite = 1 in the cycle after edge k+1; no same-cycle bypass.
REQ-029 Throughput: at most one write per cycle; with both queues continuously non-empty, grants alternate int, fp, int, ...
REQ-030 Ordering between the two queues is not guaranteed; decode uses chk_hit to stall dependent instructions.
REQ-031 chk_hit compares index and bank only; a queued int-bank index-0 entry cannot exist (REQ-024).

Reset
REQ-032 rst_n low at a rising edge:
- Both queues emptied; pending entries discarded without writing.
- rf_regWrite = 0, rf_writeReg = 0, rf_writeData = 0, rf_float = 0.
- err_badreg = 0; last-grant = fp (first contested grant goes to int).
REQ-033 During reset cycles int_ready = fp_ready = 0, no handshake completes, idle = 1; ready rises the cycle after the first edge sampling rst_n high.
REQ-034 Reset asserted mid-burst truncates it; no write issues on the reset edge or after, until new requests arrive.

Verification
REQ-035 Single int write {reg 5, 0xDEADBEEF} accepted at edge k -> rf_regWrite = 1, rf_writeReg = 5, rf_float = 0 in the cycle after edge k+1; idle returns to 1 after it.
REQ-036 Both valid every cycle, QDEPTH = 2 -> grants alternate int/fp starting with int; each ready drops when its queue holds 2 entries; no request lost or duplicated.
REQ-037 int reg 0 -> no write, no error; fp reg 0 with fp_float = 1 -> write to float reg 0; fp reg 40 -> no write, err_badreg pulses one cycle.
REQ-038 fp entry {float, reg 3} queued -> chk_reg = 3 with chk_float = 1 gives chk_hit = 1, with chk_float = 0 gives 0; chk_hit clears the cycle after the write retires.
REQ-039 Fill both queues, assert rst_n low for one edge -> rf_regWrite stays 0 afterwards, idle = 1, ready returns the following cycle.
